dmem_ctrl: RTL and testbench

Memory-side responder for the CPU's load/store path. It accepts one byte-addressed RISC-V load or store request at a time over a valid/ready handshake and drives a single-port synchronous word RAM that has no byte enables. For loads it extracts the addressed byte, halfword or word and sign- or zero-extends it. For sub-word stores it performs a read-modify-write, merging the new bytes into the old word. Each request returns a response carrying the load data or an error flag.

---
 rtl/dmem_ctrl_if.sv | 51 +++++
 rtl/dmem_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - load/store request, response and RAM bus bundle for dmem_ctrl
//
// Purpose: groups the request/response handshakes and the word-RAM port.
// Modports:
//   slave  - controller side: takes requests, returns responses, drives the RAM.
//   master - CPU/RAM side: issues requests, consumes responses, returns RAM read data.
// Signals:
//   req_valid/req_ready/req_we/req_addr/req_funct3/req_wdata  request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                     response channel
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata                single-port word RAM

interface dmem_ctrl_if #(
    parameter int XLEN = 32,
    parameter int AW   = 30
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [31:0]     req_addr;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_wdata;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-addressed RISC-V load/store responder over a word RAM
//
// Purpose: serves one load or store at a time. Loads extract and extend the
// addressed byte/halfword/word; sub-word stores read-modify-write the RAM word
// because the RAM has no byte enables. Misaligned or illegal accesses return an
// error response without touching the RAM.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - dmem_ctrl_if.slave: request, response and RAM channels

module dmem_ctrl #(
    parameter int XLEN = 32,
    parameter int AW   = 30
) (
    input logic        clk,
    input logic        rst,
    dmem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDW,
        S_WR,
        S_RSP
    } state_t;

    state_t          r_state;
    logic            r_req_ready;
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic [XLEN-1:0] r_rsp_rdata;
    logic            r_mem_en;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [31:0]     r_mem_wdata;

    // Latched request fields
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [1:0]      r_lane;
    logic [15:0]     r_wdata;

    logic            w_req_err;
    logic            w_req_sw;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;
    logic [31:0]     w_merged;

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    // Classification of the incoming request; only consulted in IDLE.
    always_comb begin
        w_req_err = 1'b0;
        if (bus.req_we) begin
            w_req_err = (bus.req_funct3 >= 3'b011);
        end else begin
            w_req_err = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
        end
        case (bus.req_funct3[1:0])
            2'b01:   if (bus.req_addr[0])          w_req_err = 1'b1;
            2'b10:   if (bus.req_addr[1:0] != 2'b00) w_req_err = 1'b1;
            default: ;
        endcase
    end

    assign w_req_sw = bus.req_we && (bus.req_funct3 == 3'b010);

    // Lane selection and extension of the RAM word read during RDW.
    always_comb begin
        w_byte = bus.mem_rdata[{r_lane, 3'b000} +: 8];
        w_half = bus.mem_rdata[{r_lane[1], 4'b0000} +: 16];
        w_load = '0;
        case (r_funct3[1:0])
            2'b00: begin
                if (r_funct3[2]) w_load = XLEN'(w_byte);
                else             w_load = XLEN'($signed(w_byte));
            end
            2'b01: begin
                if (r_funct3[2]) w_load = XLEN'(w_half);
                else             w_load = XLEN'($signed(w_half));
            end
            default: w_load = XLEN'($signed(bus.mem_rdata));
        endcase
    end

    // Read-modify-write merge: only the addressed byte/halfword is replaced.
    always_comb begin
        w_merged = bus.mem_rdata;
        if (r_funct3[1:0] == 2'b00) begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_lane      <= 2'b00;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_we        <= bus.req_we;
                        r_funct3    <= bus.req_funct3;
                        r_lane      <= bus.req_addr[1:0];
                        r_wdata     <= bus.req_wdata[15:0];
                        r_req_ready <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= w_req_err;
                        if (w_req_err) begin
                            // Errors skip the RAM entirely; mem_addr/mem_wdata keep old values.
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RSP;
                        end else begin
                            r_mem_addr <= bus.req_addr[AW+1:2];
                            r_mem_en   <= 1'b1;
                            if (w_req_sw) begin
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= bus.req_wdata[31:0];
                                r_state     <= S_WR;
                            end else begin
                                r_state <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    r_mem_en <= 1'b0;
                    r_state  <= S_RDW;
                end
                S_RDW: begin
                    if (r_we) begin
                        r_mem_wdata <= w_merged;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_state     <= S_WR;
                    end else begin
                        r_rsp_rdata <= w_load;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_WR: begin
                    r_mem_en    <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RSP;
                end
                S_RSP: begin
                    // Returning to IDLE first keeps request acceptance out of the handshake cycle.
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_mem_en    <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl

module tb_dmem_ctrl;
    localparam int XLEN = 32;
    localparam int AW   = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;

    always #5 clk = ~clk;

    dmem_ctrl_if #(.XLEN(XLEN), .AW(AW)) bus ();

    dmem_ctrl #(.XLEN(XLEN), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Word RAM model: one-cycle read latency, no byte enables.
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
            ram[8'h40] <= 32'h8899AABB;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr[7:0]];
        end
    end

    int checks   = 0;
    int failures = 0;

    int              lat;
    int              nrd;
    int              nwr;
    int              rdcyc;
    int              wrcyc;
    logic [31:0]     rdaddr;
    logic [31:0]     wraddr;
    logic [31:0]     wrdata;
    logic [XLEN-1:0] rdata;
    logic            err;
    int              k;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample_mem(input int cyc);
        if (bus.mem_en && !bus.mem_we) begin
            nrd++;
            rdcyc  = cyc;
            rdaddr = 32'(bus.mem_addr);
        end
        if (bus.mem_en && bus.mem_we) begin
            nwr++;
            wrcyc  = cyc;
            wraddr = 32'(bus.mem_addr);
            wrdata = bus.mem_wdata;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the response handshake.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
        nrd = 0; nwr = 0; rdcyc = -1; wrcyc = -1;
        rdaddr = '0; wraddr = '0; wrdata = '0;
        chk("req_ready_before", 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) bus.req_valid = 1'b0;
            sample_mem(k);
        end while (!bus.rsp_valid && k < 20);
        lat   = k;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        @(negedge clk);
    endtask

    task automatic chk_rsp(input string tag, input int exp_lat, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_nrd, input int exp_nwr);
        chk({tag, "_lat"},   64'(lat),   64'(exp_lat));
        chk({tag, "_rdata"}, 64'(rdata), 64'(exp_rdata));
        chk({tag, "_err"},   64'(err),   64'(exp_err));
        chk({tag, "_nrd"},   64'(nrd),   64'(exp_nrd));
        chk({tag, "_nwr"},   64'(nwr),   64'(exp_nwr));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
        chk({tag, "_rsp_err"},   64'(bus.rsp_err),   64'd0);
        chk({tag, "_mem_en"},    64'(bus.mem_en),    64'd0);
        chk({tag, "_mem_we"},    64'(bus.mem_we),    64'd0);
        chk({tag, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
        chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b1;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_held");
        preload = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset_released");

        // Loads from word 0x40 = 0x8899AABB
        do_req(1'b0, 3'b000, 32'h101, 32'h0); chk_rsp("lb_101",  3, 32'hFFFFFFAA, 1'b0, 1, 0);
        chk("lb_rdcyc", 64'(rdcyc), 64'd1);
        chk("lb_rdaddr", 64'(rdaddr), 64'h40);
        do_req(1'b0, 3'b100, 32'h103, 32'h0); chk_rsp("lbu_103", 3, 32'h00000088, 1'b0, 1, 0);
        do_req(1'b0, 3'b001, 32'h102, 32'h0); chk_rsp("lh_102",  3, 32'hFFFF8899, 1'b0, 1, 0);
        do_req(1'b0, 3'b101, 32'h100, 32'h0); chk_rsp("lhu_100", 3, 32'h0000AABB, 1'b0, 1, 0);
        do_req(1'b0, 3'b010, 32'h100, 32'h0); chk_rsp("lw_100",  3, 32'h8899AABB, 1'b0, 1, 0);

        // Sub-word stores: read-modify-write
        do_req(1'b1, 3'b000, 32'h102, 32'h123456CC); chk_rsp("sb_102", 4, 32'h0, 1'b0, 1, 1);
        chk("sb_rdcyc",  64'(rdcyc),  64'd1);
        chk("sb_wrcyc",  64'(wrcyc),  64'd3);
        chk("sb_wraddr", 64'(wraddr), 64'h40);
        chk("sb_wrdata", 64'(wrdata), 64'h88CCAABB);
        chk("sb_ram",    64'(ram[8'h40]), 64'h88CCAABB);
        do_req(1'b1, 3'b001, 32'h102, 32'h0000BEEF); chk_rsp("sh_102", 4, 32'h0, 1'b0, 1, 1);
        chk("sh_wrdata", 64'(wrdata), 64'hBEEFAABB);
        chk("sh_ram",    64'(ram[8'h40]), 64'hBEEFAABB);

        // Full-word store: no read
        do_req(1'b1, 3'b010, 32'h104, 32'hDEADBEEF); chk_rsp("sw_104", 2, 32'h0, 1'b0, 0, 1);
        chk("sw_wrcyc",  64'(wrcyc),  64'd1);
        chk("sw_wraddr", 64'(wraddr), 64'h41);
        chk("sw_ram",    64'(ram[8'h41]), 64'hDEADBEEF);

        // Errors: no RAM access, rdata zero
        do_req(1'b0, 3'b001, 32'h101, 32'h0);        chk_rsp("err_lh_mis",  1, 32'h0, 1'b1, 0, 0);
        do_req(1'b1, 3'b010, 32'h106, 32'h11112222); chk_rsp("err_sw_mis",  1, 32'h0, 1'b1, 0, 0);
        do_req(1'b0, 3'b011, 32'h100, 32'h0);        chk_rsp("err_ld_f3",   1, 32'h0, 1'b1, 0, 0);
        do_req(1'b1, 3'b100, 32'h100, 32'h33334444); chk_rsp("err_st_f3",   1, 32'h0, 1'b1, 0, 0);
        chk("err_ram40", 64'(ram[8'h40]), 64'hBEEFAABB);
        chk("err_ram41", 64'(ram[8'h41]), 64'hDEADBEEF);

        // Backpressure with a second request held pending
        bus.rsp_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h104;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus.req_funct3 = 3'b100;
                bus.req_addr   = 32'h100;
            end
        end while (!bus.rsp_valid && k < 20);
        chk("bp_lat", 64'(k), 64'd3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_rsp_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
            chk("bp_rsp_err",   64'(bus.rsp_err),   64'd0);
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
            if (i < 4) @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_after_hs_req_ready", 64'(bus.req_ready), 64'd1);
        chk("bp_after_hs_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        chk("bp_second_accepted", 64'(bus.req_ready), 64'd0);
        bus.req_valid = 1'b0;
        k = 1;
        while (!bus.rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("bp2_lat",   64'(k), 64'd3);
        chk("bp2_rdata", 64'(bus.rsp_rdata), 64'hBB);
        @(negedge clk);

        // Reset during the WR phase of an SB
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h100;
        bus.req_wdata  = 32'h00000077;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) bus.req_valid = 1'b0;
        end while (!bus.mem_we && k < 20);
        chk("rst_wr_cycle", 64'(k), 64'd3);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid_wr");
        @(negedge clk);
        @(negedge clk);
        chk("rst_ram_unchanged", 64'(ram[8'h40]), 64'hBEEFAABB);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_after");
        do_req(1'b0, 3'b010, 32'h100, 32'h0); chk_rsp("lw_after_rst", 3, 32'hBEEFAABB, 1'b0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
